// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT command front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

   localparam logic [7:0]  OP_NOP      = 8'h00;
   localparam logic [7:0]  OP_SET_Q_LO = 8'hF0;
   localparam logic [7:0]  OP_SET_Q_HI = 8'hF1;

   localparam int          OPC_LSB     = 56;
   localparam int          SLOT_LSB    = 52;
   localparam int          MODSEL_LSB  = 50;
   localparam int          PAYLOAD_W   = 48;

   localparam logic [63:0] DEFAULT_Q   = 64'h0800000000000001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LO = 2'd1,
      WAIT_HI = 2'd2
   } state_t;

   // Host command word layout, MSB first.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [3:0]  slot;
      logic [1:0]  modsel;
      logic [1:0]  rsvd;
      logic [47:0] payload;
   } cmd_t;

endpackage

// File: rtl/ntt_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: full flag must gate pushes; pop must only be asserted when not empty.
module ntt_cmd_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head_dat,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/ntt_core_q.sv
// NTT command front-end: queues host commands, applies modulus-table writes, issues compute ops.
// Latency: issue pulse and eng_* fields appear the cycle after a compute op is popped.
// Backpressure: cmd_ready drops when the queue is full; compute ops wait at the head for eng_ready.
module ntt_core_q #(
   parameter int          CORE_ID    = 0,
   parameter int          CMDQ_DEPTH = 4,
   parameter int          NUM_MOD    = 4,
   parameter logic [63:0] DEFAULT_Q  = ntt_pkg::DEFAULT_Q
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [63:0] cmd_data,
   output logic        cmd_ready,
   output logic        idle,
   output logic        eng_cmd_valid,
   output logic [7:0]  eng_opcode,
   output logic [3:0]  eng_slot,
   output logic [47:0] eng_dma_addr,
   output logic [63:0] eng_q,
   input  logic        eng_ready,
   output logic [63:0] op_count,
   output logic [63:0] busy_cycles,
   output logic [63:0] stall_cycles,
   output logic [7:0]  core_id
);
   import ntt_pkg::*;

   localparam int CW = $clog2(CMDQ_DEPTH) + 1;

   logic          w_push, w_pop, w_full, w_empty;
   logic [CW-1:0] w_count;
   logic [63:0]   w_head_dat;
   cmd_t          w_head;
   logic [1:0]    w_msel;
   logic          w_is_cfg, w_is_compute;
   logic          w_issue, w_cfg_we, w_done, w_stall;
   logic          w_unused_rsvd;
   state_t        r_state, w_state_nxt;

   // Table is sized for the largest modsel; entries at or above NUM_MOD stay at reset value.
   logic [63:0]   r_table [4];
   logic          r_eng_cmd_valid;
   logic [7:0]    r_eng_opcode;
   logic [3:0]    r_eng_slot;
   logic [47:0]   r_eng_dma_addr;
   logic [63:0]   r_eng_q;
   logic [63:0]   r_op_count, r_busy_cycles, r_stall_cycles;

   assign w_push = cmd_valid && !w_full;

   ntt_cmd_fifo #(.WIDTH(64), .DEPTH(CMDQ_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_dat (cmd_data),
      .i_pop      (w_pop),
      .o_head_dat (w_head_dat),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign w_head        = cmd_t'(w_head_dat);
   assign w_unused_rsvd = ^w_head.rsvd;   // reserved command bits are ignored
   assign w_msel        = (int'(w_head.modsel) >= NUM_MOD) ? 2'd0 : w_head.modsel;
   assign w_is_cfg      = (w_head.opcode == OP_SET_Q_LO) || (w_head.opcode == OP_SET_Q_HI);
   assign w_is_compute  = !w_is_cfg && (w_head.opcode != OP_NOP);
   assign w_stall       = (r_state == IDLE) && !w_empty && w_is_compute && !eng_ready;

   // Dispatch: config/NOP drain one per cycle in IDLE; compute issues then waits for the engine handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_issue     = 1'b0;
      w_cfg_we    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               if (w_is_compute) begin
                  if (eng_ready) begin
                     w_pop       = 1'b1;
                     w_issue     = 1'b1;
                     w_state_nxt = WAIT_LO;
                  end
               end else begin
                  w_pop    = 1'b1;
                  w_cfg_we = w_is_cfg;
               end
            end
         end
         WAIT_LO: if (!eng_ready) w_state_nxt = WAIT_HI;
         WAIT_HI: begin
            if (eng_ready) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Modulus table: config ops overwrite one 32-bit half of the selected entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_table[i] <= DEFAULT_Q;
      end else if (w_cfg_we) begin
         if (w_head.opcode == OP_SET_Q_HI) r_table[w_msel][63:32] <= w_head.payload[31:0];
         else                              r_table[w_msel][31:0]  <= w_head.payload[31:0];
      end
   end

   // Engine interface: fields and modulus latched at issue and held until the next issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_eng_cmd_valid <= 1'b0;
         r_eng_opcode    <= '0;
         r_eng_slot      <= '0;
         r_eng_dma_addr  <= '0;
         r_eng_q         <= '0;
      end else begin
         r_eng_cmd_valid <= w_issue;
         if (w_issue) begin
            r_eng_opcode   <= w_head.opcode;
            r_eng_slot     <= w_head.slot;
            r_eng_dma_addr <= w_head.payload;
            r_eng_q        <= r_table[w_msel];
         end
      end
   end

   // Performance counters, free-running modulo 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_count     <= '0;
         r_busy_cycles  <= '0;
         r_stall_cycles <= '0;
      end else begin
         r_op_count     <= r_op_count + 64'(w_done);
         r_busy_cycles  <= r_busy_cycles + 64'(r_state != IDLE);
         r_stall_cycles <= r_stall_cycles + 64'(w_stall);
      end
   end

   assign cmd_ready     = !w_full;
   assign idle          = (w_count == '0) && (r_state == IDLE);
   assign eng_cmd_valid = r_eng_cmd_valid;
   assign eng_opcode    = r_eng_opcode;
   assign eng_slot      = r_eng_slot;
   assign eng_dma_addr  = r_eng_dma_addr;
   assign eng_q         = r_eng_q;
   assign op_count      = r_op_count;
   assign busy_cycles   = r_busy_cycles;
   assign stall_cycles  = r_stall_cycles;
   assign core_id       = 8'(CORE_ID);

endmodule

// File: tb/tb_ntt_core_q.sv
// Bench for ntt_core_q: directed scenarios plus randomized command stream against a transaction model.
// Latency: n/a.
// Backpressure: pushes wait on cmd_ready with a bounded cycle budget.
module tb_ntt_core_q;
   localparam int          DEPTH = 4;
   localparam int          NMOD  = 3;
   localparam int          CID   = 5;
   localparam logic [63:0] DQ    = 64'h0800000000000001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [63:0] cmd_data = '0;
   logic        cmd_ready, idle, eng_cmd_valid, eng_ready;
   logic [7:0]  eng_opcode, core_id;
   logic [3:0]  eng_slot;
   logic [47:0] eng_dma_addr;
   logic [63:0] eng_q, op_count, busy_cycles, stall_cycles;

   logic auto_eng = 1'b1, auto_rdy = 1'b1, man_rdy = 1'b1;
   assign eng_ready = auto_eng ? auto_rdy : man_rdy;

   always #5 clk = ~clk;

   ntt_core_q #(.CORE_ID(CID), .CMDQ_DEPTH(DEPTH), .NUM_MOD(NMOD), .DEFAULT_Q(DQ)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .idle(idle), .eng_cmd_valid(eng_cmd_valid), .eng_opcode(eng_opcode), .eng_slot(eng_slot),
      .eng_dma_addr(eng_dma_addr), .eng_q(eng_q), .eng_ready(eng_ready), .op_count(op_count),
      .busy_cycles(busy_cycles), .stall_cycles(stall_cycles), .core_id(core_id)
   );

   typedef struct {
      logic [7:0]  op;
      logic [3:0]  slot;
      logic [47:0] addr;
      logic [63:0] q;
   } iss_t;

   int          checks = 0, errors = 0;
   iss_t        exp_q[$];
   logic [63:0] m_table [4];
   int          m_issued = 0, pulses = 0, fixed_b = 0, e_cnt = 0, e_b = 0;
   longint      sum_busy = 0;
   bit          in_reset = 1'b1, prev_vld = 1'b0;
   logic [63:0] held_q = '0, pb = '0, ps = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [7:0] op, input logic [3:0] sl,
                                      input logic [1:0] ms, input logic [47:0] pl);
      return {op, sl, ms, 2'b00, pl};
   endfunction

   // Transaction model: commands take effect in queue order, so the modulus an op will
   // carry is fixed the moment it is queued behind all earlier table writes.
   task automatic model_push(input logic [63:0] d);
      logic [7:0] op;
      logic [1:0] ms;
      iss_t       e;
      op = d[63:56];
      ms = d[51:50];
      if (int'(ms) >= NMOD) ms = 2'd0;
      if (op == 8'hF0)      m_table[ms][31:0]  = d[31:0];
      else if (op == 8'hF1) m_table[ms][63:32] = d[31:0];
      else if (op != 8'h00) begin
         e.op = op; e.slot = d[55:52]; e.addr = d[47:0]; e.q = m_table[ms];
         exp_q.push_back(e);
         m_issued++;
      end
   endtask

   task automatic push(input logic [63:0] d);
      int n;
      cmd_data  = d;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout actual=cmd_ready=0 required=1");
         cmd_valid = 1'b0;
      end else begin
         @(negedge clk);
         cmd_valid = 1'b0;
         model_push(d);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(idle && e_cnt == 0 && exp_q.size() == 0) && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL drain_timeout actual=pending=%0d required=0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_reset = 1'b1; rst = 1'b1; cmd_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_table[i] = DQ;
      m_issued = 0; held_q = '0; prev_vld = 1'b0; pulses = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_op_count", op_count, 64'd0);
      chk("rst_busy", busy_cycles, 64'd0);
      chk("rst_stall", stall_cycles, 64'd0);
      chk("rst_eng_vld", 64'(eng_cmd_valid), 64'd0);
      chk("rst_eng_q", eng_q, 64'd0);
      chk("core_id", 64'(core_id), 64'(CID));
      in_reset = 1'b0;
   endtask

   // Engine stand-in: drops ready on each issue pulse for B cycles; each op is then busy for B+1 cycles.
   always @(negedge clk) begin
      if (rst) begin
         auto_rdy = 1'b1; e_cnt = 0; sum_busy = 0;
      end else if (eng_cmd_valid) begin
         e_b      = (fixed_b > 0) ? fixed_b : int'($urandom_range(1, 4));
         auto_rdy = 1'b0;
         e_cnt    = e_b;
         sum_busy += longint'(e_b + 1);
      end else if (e_cnt > 0) begin
         e_cnt--;
         if (e_cnt == 0) auto_rdy = 1'b1;
      end
   end

   // Per-cycle comparison of the engine interface and counters against the model.
   always @(negedge clk) begin
      if (!rst && !in_reset) begin
         if (eng_cmd_valid) begin
            iss_t e;
            pulses++;
            checks++;
            if (prev_vld) begin
               errors++;
               $display("FAIL pulse_width actual=2+ cycles required=1");
            end
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_issue actual=op %h required=no issue", eng_opcode);
            end else begin
               e = exp_q.pop_front();
               chk("iss_opcode", 64'(eng_opcode), 64'(e.op));
               chk("iss_slot", 64'(eng_slot), 64'(e.slot));
               chk("iss_addr", 64'(eng_dma_addr), 64'(e.addr));
               chk("iss_q", eng_q, e.q);
               held_q = e.q;
            end
         end else begin
            chk("eng_q_held", eng_q, held_q);
         end
         chk("busy_stall_excl", 64'((busy_cycles - pb) + (stall_cycles - ps) <= 64'd1), 64'd1);
         chk("op_count_bound", 64'(op_count <= 64'(m_issued)), 64'd1);
      end
      prev_vld = eng_cmd_valid;
      pb = busy_cycles;
      ps = stall_cycles;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] s0, d;
      int          n;

      // 1: single compute from reset
      do_reset();
      fixed_b = 2;
      push(mk(8'h10, 4'd3, 2'd0, 48'h0000_1234_5678));
      wait_idle();
      chk("t1_pulses", 64'(pulses), 64'd1);
      chk("t1_eng_q", eng_q, DQ);
      chk("t1_slot", 64'(eng_slot), 64'd3);
      chk("t1_op_count", op_count, 64'd1);
      chk("t1_busy", busy_cycles, 64'd3);
      chk("t1_vld_low", 64'(eng_cmd_valid), 64'd0);

      // 2: table writes then compute on modsel 1
      push(mk(8'hF0, 4'd0, 2'd1, 48'h1));
      push(mk(8'hF1, 4'd0, 2'd1, 48'h0FFF_0000));
      push(mk(8'h22, 4'd5, 2'd1, 48'hABCD));
      wait_idle();
      chk("t2_eng_q", eng_q, 64'h0FFF000000000001);

      // 3: engine not ready, queue fills, stall counts
      do_reset();
      auto_eng = 1'b0; man_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push(mk(8'h30 + 8'(i), 4'(i), 2'(i), 48'(i * 16)));
      chk("t3_full", 64'(cmd_ready), 64'd0);
      s0 = stall_cycles;
      cmd_data = mk(8'h34, 4'd4, 2'd0, 48'h40); cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_held", 64'(cmd_ready), 64'd0);
      end
      chk("t3_stall", stall_cycles - s0, 64'd3);
      chk("t3_no_issue", 64'(pulses), 64'd0);
      auto_eng = 1'b1;
      push(mk(8'h34, 4'd4, 2'd0, 48'h40));
      wait_idle();
      chk("t3_op_count", op_count, 64'd5);

      // 4: config behind an in-flight compute does not disturb its modulus
      do_reset();
      fixed_b = 8;
      push(mk(8'h30, 4'd1, 2'd0, 48'h100));
      push(mk(8'hF0, 4'd0, 2'd0, 48'hABCD));
      n = 0;
      while (pulses == 0 && n < 50) begin @(negedge clk); n++; end
      while (op_count != 64'd1 && n < 100) begin
         chk("t4_q_hold", eng_q, DQ);
         @(negedge clk); n++;
      end
      chk("t4_op_count", op_count, 64'd1);
      wait_idle();
      push(mk(8'h31, 4'd2, 2'd0, 48'h200));
      wait_idle();
      chk("t4_new_q", eng_q, 64'h080000000000ABCD);

      // 5: reset while waiting on the engine with two commands queued
      do_reset();
      fixed_b = 10;
      push(mk(8'hF0, 4'd0, 2'd1, 48'h77));
      push(mk(8'h40, 4'd1, 2'd1, 48'h300));
      n = 0;
      while (pulses == 0 && n < 50) begin @(negedge clk); n++; end
      push(mk(8'h41, 4'd2, 2'd1, 48'h400));
      push(mk(8'h42, 4'd3, 2'd2, 48'h500));
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 6; i++) @(negedge clk);
      chk("t5_no_issue", 64'(pulses), 64'd0);
      chk("t5_idle", 64'(idle), 64'd1);
      fixed_b = 2;
      push(mk(8'h43, 4'd4, 2'd1, 48'h600));
      wait_idle();
      chk("t5_table_reset", eng_q, DQ);

      // 6: push and pop together at occupancy 3, across pointer wrap; modsel 3 aliases to 0
      do_reset();
      fixed_b = 6;
      push(mk(8'h50, 4'd0, 2'd0, 48'h1));
      for (int i = 0; i < 4; i++) push(mk(8'hF0 + 8'(i & 1), 4'd0, 2'(i), 48'(32'h1000 + i)));
      chk("t6_full", 64'(cmd_ready), 64'd0);
      for (int i = 0; i < 6; i++) push(mk(8'hF0 + 8'(i % 2), 4'd0, 2'(i + 1), 48'($urandom)));
      for (int i = 0; i < 4; i++) push(mk(8'h60 + 8'(i), 4'(i), 2'(i), 48'(i)));
      wait_idle();
      chk("t6_op_count", op_count, 64'd5);

      // Random command stream against the model
      do_reset();
      fixed_b = 0;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       d = 64'h0;
            1:       d = {8'hF0, 56'(({$urandom, $urandom}))};
            2:       d = {8'hF1, 56'(({$urandom, $urandom}))};
            default: d = {8'($urandom_range(1, 255)), 56'(({$urandom, $urandom}))};
         endcase
         push(d);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
      end
      wait_idle();
      chk("rnd_op_count", op_count, 64'(m_issued));
      chk("rnd_busy", busy_cycles, 64'(sum_busy));
      chk("rnd_stall", stall_cycles, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
